// File: rtl/nr_root_streamer.sv
// nr_root_streamer
//
// Sits behind the Newton-Raphson solver. Every time the solver's done flag
// rises, the root triplet (xn, yn, zn) is captured into a small FIFO of
// result sets. Stored sets are then streamed out one at a time as 4-word
// packets over a valid/ready interface:
//    word 0 : header {SYNC[7:0], seq[7:0], drop[15:0]}
//    word 1 : x
//    word 2 : y
//    word 3 : z   (m_last = 1)
// The FIFO lets the solver run ahead of a slow sink (UART, DMA, logger).
// When the FIFO is full a new set is dropped. The drop is counted in the
// header and also raises the sticky overflow flag.
//
// Parameters
//    dw     width of roots and stream words (Q8.24 passes through untouched)
//    DEPTH  number of result sets held (power of 2, >= 2)
//    SYNC   header sync byte
//
// Ports
//    clk         system clock, rising edge
//    rst         asynchronous reset, active low
//    rootsFound  solver done flag (level, may stay high for many cycles)
//    xn, yn, zn  root triplet, valid while rootsFound is high
//    m_data      stream word (registered)
//    m_valid     stream word valid
//    m_ready     sink ready
//    m_last      high on the z word of each packet
//    count       number of sets currently stored
//    overflow    sticky, set once any set has been dropped since reset

module nr_root_streamer #(
   parameter int          dw    = 32,
   parameter int          DEPTH = 4,
   parameter logic [7:0]  SYNC  = 8'hA5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rootsFound,
   input  logic [dw-1:0]              xn,
   input  logic [dw-1:0]              yn,
   input  logic [dw-1:0]              zn,
   output logic [dw-1:0]              m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic                       m_last,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      WX,
      WY,
      WZ
   } state_t;

   state_t          state;
   state_t          next_state;

   logic [dw-1:0]   mem_x [DEPTH];
   logic [dw-1:0]   mem_y [DEPTH];
   logic [dw-1:0]   mem_z [DEPTH];

   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count_next;
   logic [7:0]      seq;
   logic [15:0]     drop_cnt;
   logic            rf_d;

   logic            rise;
   logic            is_full;
   logic            push;
   logic            drop_ev;
   logic            handshake;
   logic            pop;
   logic [dw-1:0]   next_data;

   // Capture decisions. The full test uses the registered count, so a set
   // that arrives in the same cycle as a pop from a full FIFO is still
   // dropped.
   always_comb begin
      rise      = rootsFound & ~rf_d;
      is_full   = (count == CW'(DEPTH));
      push      = rise & ~is_full;
      drop_ev   = rise & is_full;
      handshake = m_valid & m_ready;
      pop       = (state == WZ) & handshake;
   end

   // Occupancy after this edge. The WZ exit decision uses it, so a set
   // pushed in the same cycle as the final pop still starts the next
   // packet with no idle gap.
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
   end

   // Edge detector, pointers, occupancy, packet sequence number and the
   // saturating drop counter. All of these clear on reset, so a packet cut
   // off by reset is simply lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_d     <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         seq      <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         rf_d  <= rootsFound;
         count <= count_next;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            seq    <= seq + 8'd1;
         end
         if (drop_ev) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
               drop_cnt <= drop_cnt + 16'd1;
            end
         end
      end
   end

   // Result-set storage. Its contents are meaningless until they are
   // written, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_x[wr_ptr] <= xn;
         mem_y[wr_ptr] <= yn;
         mem_z[wr_ptr] <= zn;
      end
   end

   // Packet sequencer. next_data is the word that will be on m_data after
   // the edge. It only changes when the state advances, so the output
   // stays still while the sink stalls. The header takes seq and drop as
   // they are when HDR is entered. Coming out of WZ, the sequence number
   // is the post-increment value.
   always_comb begin
      next_state = state;
      next_data  = m_data;
      case (state)
         IDLE: begin
            if (count != '0) begin
               next_state = HDR;
               next_data  = dw'({SYNC, seq, drop_cnt});
            end
         end
         HDR: begin
            if (handshake) begin
               next_state = WX;
               next_data  = mem_x[rd_ptr];
            end
         end
         WX: begin
            if (handshake) begin
               next_state = WY;
               next_data  = mem_y[rd_ptr];
            end
         end
         WY: begin
            if (handshake) begin
               next_state = WZ;
               next_data  = mem_z[rd_ptr];
            end
         end
         WZ: begin
            if (handshake) begin
               if (count_next != '0) begin
                  next_state = HDR;
                  next_data  = dw'({SYNC, seq + 8'd1, drop_cnt});
               end else begin
                  next_state = IDLE;
                  next_data  = '0;
               end
            end
         end
         default: begin
            next_state = IDLE;
            next_data  = '0;
         end
      endcase
   end

   // State and registered stream outputs. m_valid and m_last come from the
   // next state, so they line up with the word loaded into m_data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         m_data  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else begin
         state   <= next_state;
         m_data  <= next_data;
         m_valid <= (next_state != IDLE);
         m_last  <= (next_state == WZ);
      end
   end

endmodule

// File: tb/tb_nr_root_streamer.sv
// tb_nr_root_streamer
//
// Directed bench for nr_root_streamer.
// - A table of per-cycle vectors covers a single packet and a sink stall
//   on the y word.
// - Hand-written sequences cover overflow, a level-held done flag, reset
//   in the middle of a packet, and sequence wrap across 257 back-to-back
//   packets.
// - A negedge monitor logs every accepted word, so packet contents can be
//   checked after the stimulus has run.

module tb_nr_root_streamer;

   localparam int DW = 32;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rootsFound = 1'b0;
   logic [DW-1:0] xn = '0;
   logic [DW-1:0] yn = '0;
   logic [DW-1:0] zn = '0;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          m_last;
   logic [CW-1:0] count;
   logic          overflow;

   int passCnt  = 0;
   int checkCnt = 0;

   nr_root_streamer #(.dw(DW), .DEPTH(4), .SYNC(8'hA5)) dut (
      .clk        (clk),
      .rst        (rst),
      .rootsFound (rootsFound),
      .xn         (xn),
      .yn         (yn),
      .zn         (zn),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .count      (count),
      .overflow   (overflow)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Word monitor. It samples at the negedge, where the ready and valid
   // values that the next rising edge will act on are stable.
   logic [31:0] rxData [$];
   logic        rxLast [$];
   int          pktCount = 0;

   always @(negedge clk) begin
      if (rst && m_valid && m_ready) begin
         rxData.push_back(m_data);
         rxLast.push_back(m_last);
         if (m_last) pktCount++;
      end
   end

   // Gap watcher. While enabled, it counts cycles with m_valid low before
   // gapTarget packets have been delivered since gapPktBase.
   bit gapWatch   = 1'b0;
   int gapPktBase = 0;
   int gapTarget  = 0;
   int gapCnt     = 0;

   always @(negedge clk) begin
      if (gapWatch && !m_valid && (pktCount - gapPktBase) < gapTarget) gapCnt++;
   end

   typedef struct {
      logic        rf;
      logic        rdy;
      logic        eValid;
      logic [31:0] eData;
      logic        eLast;
      logic [2:0]  eCount;
      string       tag;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(input logic rf, input logic rdy, input logic ev,
                               input logic [31:0] ed, input logic el,
                               input logic [2:0] ec, input string tag);
      vec_t v;
      v.rf = rf; v.rdy = rdy; v.eValid = ev; v.eData = ed;
      v.eLast = el; v.eCount = ec; v.tag = tag;
      return v;
   endfunction

   function automatic logic [31:0] rxAt(input int idx);
      if (idx < rxData.size()) return rxData[idx];
      return 32'hDEADBEEF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCnt++;
      if (act === exp) passCnt++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Drive the inputs, then step one rising edge and settle 1 ns past it.
   task automatic applyStimulus(input logic rf, input logic rdy);
      rootsFound = rf;
      m_ready    = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input bit checkIt);
      @(negedge clk);
      rst        = 1'b0;
      rootsFound = 1'b0;
      m_ready    = 1'b0;
      #1;
      if (checkIt) begin
         checkOutput("reset m_valid", 32'(m_valid), 32'd0);
         checkOutput("reset m_last", 32'(m_last), 32'd0);
         checkOutput("reset m_data", m_data, 32'd0);
         checkOutput("reset count", 32'(count), 32'd0);
         checkOutput("reset overflow", 32'(overflow), 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic waitWords(input int target, input int budget, input string name);
      int c = 0;
      while (rxData.size() < target && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      checkOutput(name, 32'(rxData.size() >= target), 32'd1);
   endtask

   initial begin
      int base;
      int basePkt;
      int maxCnt;
      int errs;
      int c;

      doReset(1'b1);

      // Single packet, then the same packet with a 5-cycle stall on the y word
      xn = 32'h01000000; yn = 32'h02000000; zn = 32'h03000000;
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 3'd1, "t1 capture"));
      vecs.push_back(mk(1, 1, 1, 32'hA5000000, 0, 3'd1, "t1 hdr"));
      vecs.push_back(mk(0, 1, 1, 32'h01000000, 0, 3'd1, "t1 x"));
      vecs.push_back(mk(0, 1, 1, 32'h02000000, 0, 3'd1, "t1 y"));
      vecs.push_back(mk(0, 1, 1, 32'h03000000, 1, 3'd1, "t1 z"));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 3'd0, "t1 idle"));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 3'd1, "t2 capture"));
      vecs.push_back(mk(1, 1, 1, 32'hA5010000, 0, 3'd1, "t2 hdr"));
      vecs.push_back(mk(0, 1, 1, 32'h01000000, 0, 3'd1, "t2 x"));
      vecs.push_back(mk(0, 1, 1, 32'h02000000, 0, 3'd1, "t2 y"));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, 1, 32'h02000000, 0, 3'd1, "t2 y stall"));
      vecs.push_back(mk(0, 1, 1, 32'h03000000, 1, 3'd1, "t2 z"));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 3'd0, "t2 idle"));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rf, vecs[i].rdy);
         checkOutput({vecs[i].tag, " m_valid"}, 32'(m_valid), 32'(vecs[i].eValid));
         checkOutput({vecs[i].tag, " m_last"}, 32'(m_last), 32'(vecs[i].eLast));
         checkOutput({vecs[i].tag, " count"}, 32'(count), 32'(vecs[i].eCount));
         if (vecs[i].eValid) checkOutput({vecs[i].tag, " m_data"}, m_data, vecs[i].eData);
      end

      // Overflow: five sets with the sink stalled. The first header is
      // latched as soon as the first set lands, before any drop happens, so
      // it carries drop=0. Later headers show the single drop.
      doReset(1'b0);
      for (int p = 0; p < 5; p++) begin
         xn = 32'h10000000 + p; yn = 32'h20000000 + p; zn = 32'h30000000 + p;
         for (int k = 0; k < 3; k++) applyStimulus(1, 0);
         for (int k = 0; k < 2; k++) applyStimulus(0, 0);
      end
      checkOutput("t3 count full", 32'(count), 32'd4);
      checkOutput("t3 overflow", 32'(overflow), 32'd1);
      base = rxData.size();
      m_ready = 1'b1;
      waitWords(base + 16, 100, "t3 drain timeout");
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("t3 pkt%0d hdr", k), rxAt(base + 4*k),
                     (k == 0) ? 32'hA5000000 : (32'hA5000001 | (k << 16)));
         checkOutput($sformatf("t3 pkt%0d x", k), rxAt(base + 4*k + 1), 32'h10000000 + k);
         checkOutput($sformatf("t3 pkt%0d z", k), rxAt(base + 4*k + 3), 32'h30000000 + k);
      end
      applyStimulus(0, 1);
      checkOutput("t3 count drained", 32'(count), 32'd0);
      checkOutput("t3 overflow sticky", 32'(overflow), 32'd1);

      // Level hold: the done flag stays high for 20 cycles
      doReset(1'b0);
      xn = 32'h0A000000; yn = 32'h0B000000; zn = 32'h0C000000;
      base = rxData.size();
      basePkt = pktCount;
      maxCnt = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1, 1);
         if (int'(count) > maxCnt) maxCnt = int'(count);
      end
      for (int k = 0; k < 10; k++) applyStimulus(0, 1);
      checkOutput("t4 max count", 32'(maxCnt), 32'd1);
      checkOutput("t4 packets", 32'(pktCount - basePkt), 32'd1);
      checkOutput("t4 words", 32'(rxData.size() - base), 32'd4);
      checkOutput("t4 hdr", rxAt(base), 32'hA5000000);

      // Reset while the y word is on the bus
      doReset(1'b0);
      xn = 32'h11111111; yn = 32'h22222222; zn = 32'h33333333;
      applyStimulus(1, 1);
      applyStimulus(0, 1);
      applyStimulus(0, 1);
      applyStimulus(0, 1);
      checkOutput("t5 on y", m_data, 32'h22222222);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("t5 m_valid async", 32'(m_valid), 32'd0);
      checkOutput("t5 count async", 32'(count), 32'd0);
      checkOutput("t5 m_last async", 32'(m_last), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      xn = 32'h44444444;
      base = rxData.size();
      applyStimulus(1, 1);
      waitWords(base + 4, 20, "t5 restart timeout");
      checkOutput("t5 restart hdr", rxAt(base), 32'hA5000000);
      checkOutput("t5 restart x", rxAt(base + 1), 32'h44444444);

      // Sequence wrap with back-to-back packets: 2 sets preloaded, then one
      // new set every 4 cycles while the sink drains one packet every 4 cycles
      doReset(1'b0);
      for (int p = 0; p < 2; p++) begin
         applyStimulus(1, 0); applyStimulus(1, 0);
         applyStimulus(0, 0); applyStimulus(0, 0);
      end
      base = rxData.size();
      basePkt = pktCount;
      gapPktBase = pktCount;
      gapTarget = 257;
      gapWatch = 1'b1;
      for (int p = 0; p < 255; p++) begin
         applyStimulus(1, 1); applyStimulus(1, 1);
         applyStimulus(0, 1); applyStimulus(0, 1);
      end
      c = 0;
      while ((pktCount - basePkt) < 257 && c < 200) begin
         applyStimulus(0, 1);
         c++;
      end
      gapWatch = 1'b0;
      checkOutput("t6 packets", 32'(pktCount - basePkt), 32'd257);
      checkOutput("t6 idle gaps", 32'(gapCnt), 32'd0);
      checkOutput("t6 overflow", 32'(overflow), 32'd0);
      errs = 0;
      for (int k = 0; k < 257; k++)
         if (rxAt(base + 4*k) !== (32'hA5000000 | ((k % 256) << 16))) errs++;
      checkOutput("t6 header seq errors", 32'(errs), 32'd0);
      checkOutput("t6 hdr 256", rxAt(base + 4*255), 32'hA5FF0000);
      checkOutput("t6 hdr 257 wrap", rxAt(base + 4*256), 32'hA5000000);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
